// File: rtl/sub_nnbit_chunk_seq.sv
// rtl/sub_nnbit_chunk_seq.sv - multi-cycle subtractor, CHUNK_WIDTH bits per cycle, valid/ready handshake.
// Optional signed-overflow output o_ovf when SUB_OVERFLOW_FLAG_EN is defined.
module sub_nnbit_chunk_seq #(
    parameter int DATA_WIDTH  = 8,
    parameter int CHUNK_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_num_a,
    input  logic [DATA_WIDTH-1:0] i_num_b,
    input  logic                  i_brw,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_res,
    output logic                  o_brw
`ifdef SUB_OVERFLOW_FLAG_EN
    ,
    output logic                  o_ovf
`endif
);

    localparam int N     = DATA_WIDTH / CHUNK_WIDTH;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [DATA_WIDTH-1:0]   r_a;
    logic [DATA_WIDTH-1:0]   r_b;
    logic [DATA_WIDTH-1:0]   r_res;
    logic                    r_brw;
    logic [IDX_W-1:0]        r_idx;
    logic                    w_last;
    logic [CHUNK_WIDTH-1:0]  w_ca;
    logic [CHUNK_WIDTH-1:0]  w_cb;
    logic [CHUNK_WIDTH-1:0]  w_g;
    logic [CHUNK_WIDTH-1:0]  w_p;
    logic [CHUNK_WIDTH-1:0]  w_diff;
    logic [CHUNK_WIDTH:0]    w_bc;

    assign w_last = (r_idx == LAST_IDX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        o_ready = 1'b0;
        o_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    w_next = S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Borrow generate/propagate across the current chunk, seeded by the registered borrow.
    always_comb begin
        w_ca    = r_a[int'(r_idx)*CHUNK_WIDTH +: CHUNK_WIDTH];
        w_cb    = r_b[int'(r_idx)*CHUNK_WIDTH +: CHUNK_WIDTH];
        w_g     = ~w_ca & w_cb;
        w_p     = ~(w_ca ^ w_cb);
        w_bc    = '0;
        w_bc[0] = r_brw;
        w_diff  = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            w_bc[i+1] = w_g[i] | (w_p[i] & w_bc[i]);
            w_diff[i] = w_ca[i] ^ w_cb[i] ^ w_bc[i];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_brw <= 1'b0;
            r_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_valid) begin
                        r_a   <= i_num_a;
                        r_b   <= i_num_b;
                        r_brw <= i_brw;
                        r_res <= '0;
                        r_idx <= '0;
                    end
                end
                S_CALC: begin
                    r_res[int'(r_idx)*CHUNK_WIDTH +: CHUNK_WIDTH] <= w_diff;
                    r_brw <= w_bc[CHUNK_WIDTH];
                    r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_res = r_res;
    assign o_brw = r_brw;

`ifdef SUB_OVERFLOW_FLAG_EN
    logic r_ovf;

    // The final chunk's top difference bit is the result MSB.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_IDLE && i_valid) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_CALC && w_last) begin
            r_ovf <= (r_a[DATA_WIDTH-1] ^ r_b[DATA_WIDTH-1]) &
                     (w_diff[CHUNK_WIDTH-1] ^ r_a[DATA_WIDTH-1]);
        end
    end

    assign o_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_sub_nnbit_chunk_seq.sv
// tb/tb_sub_nnbit_chunk_seq.sv - scoreboard bench for sub_nnbit_chunk_seq (8-bit, 4-bit chunks).
module tb_sub_nnbit_chunk_seq;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] i_num_a;
    logic [7:0] i_num_b;
    logic       i_brw;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_res;
    logic       o_brw;
`ifdef SUB_OVERFLOW_FLAG_EN
    logic       o_ovf;
`endif

    sub_nnbit_chunk_seq #(.DATA_WIDTH(8), .CHUNK_WIDTH(4)) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_num_a (i_num_a),
        .i_num_b (i_num_b),
        .i_brw   (i_brw),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_res   (o_res),
        .o_brw   (o_brw)
`ifdef SUB_OVERFLOW_FLAG_EN
        ,
        .o_ovf   (o_ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] res;
        logic       brw;
        logic       ovf;
        int         acc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic prev_v = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: latency on o_valid rise, payload on transfer.
    always @(negedge clk) begin
        if (o_valid && !prev_v) begin
            if (q.size() == 0) chk("unexpected_valid", 32'(o_valid), 32'd0);
            else               chk("latency", 32'(cyc - q[0].acc), 32'd2);
        end
        if (o_valid && i_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 32'(o_valid), 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("res", 32'(o_res), 32'(e.res));
                chk("brw", 32'(o_brw), 32'(e.brw));
`ifdef SUB_OVERFLOW_FLAG_EN
                chk("ovf", 32'(o_ovf), 32'(e.ovf));
`endif
            end
        end
        prev_v <= o_valid;
    end

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic bi,
                         input logic push, input logic [7:0] er, input logic eb,
                         input logic eo, output int acc);
        int   n;
        exp_t e;
        i_num_a = a;
        i_num_b = b;
        i_brw   = bi;
        i_valid = 1'b1;
        n = 0;
        acc = -1;
        do begin
            @(negedge clk);
            n++;
        end while (!o_ready && n < 50);
        if (!o_ready) begin
            chk("accept_timeout", 32'(o_ready), 32'd1);
            return;
        end
        acc = cyc + 1;
        if (push) begin
            e.res = er; e.brw = eb; e.ovf = eo; e.acc = acc;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(q.size() == 0 && o_ready) && n < 50);
        chk("drain_timeout", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    logic [7:0] va[5] = '{8'h12, 8'hFF, 8'hA5, 8'h00, 8'h7F};
    logic [7:0] vb[5] = '{8'h34, 8'h00, 8'h5A, 8'hFF, 8'h80};
    logic       vi[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [7:0] vr[5] = '{8'hDE, 8'hFE, 8'h4B, 8'h00, 8'hFF};
    logic       vbo[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       vo[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        int acc;
        int prev_acc;
        int n;
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        i_num_a = '0; i_num_b = '0; i_brw = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_res",   32'(o_res),   32'd0);
        chk("rst_brw",   32'(o_brw),   32'd0);
        @(posedge clk); #1;
        i_rst = 1'b0;

        issue(8'hF0, 8'hF0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, acc); i_valid = 1'b0; wait_idle();
        issue(8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, acc); i_valid = 1'b0; wait_idle();
        issue(8'h05, 8'h05, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, acc); i_valid = 1'b0; wait_idle();
        issue(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, acc); i_valid = 1'b0; wait_idle();
        issue(8'hFC, 8'hF9, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, acc); i_valid = 1'b0; wait_idle();

        i_ready = 1'b0;
        issue(8'hFE, 8'hF9, 1'b1, 1'b1, 8'h04, 1'b0, 1'b0, acc);
        i_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_valid && n < 20);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_res",   32'(o_res),   32'h04);
            chk("hold_brw",   32'(o_brw),   32'd0);
            @(posedge clk); #1;
            i_valid = ~i_valid;
            i_num_a = 8'($urandom);
            i_num_b = 8'($urandom);
            @(negedge clk);
        end
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        wait_idle();

        issue(8'h33, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, acc);
        i_valid = 1'b0;
        i_rst = 1'b1;
        @(posedge clk); #1;
        i_rst = 1'b0;
        @(negedge clk);
        chk("abort_valid", 32'(o_valid), 32'd0);
        chk("abort_res",   32'(o_res),   32'd0);
        chk("abort_ready", 32'(o_ready), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        issue(8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b1, 1'b0, acc); i_valid = 1'b0; wait_idle();

        prev_acc = 0;
        for (int i = 0; i < 5; i++) begin
            issue(va[i], vb[i], vi[i], 1'b1, vr[i], vbo[i], vo[i], acc);
            if (i > 0) chk("b2b_spacing", 32'(acc - prev_acc), 32'd4);
            prev_acc = acc;
        end
        i_valid = 1'b0;
        wait_idle();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sub_nnbit_chunk_seq.md
SUB_NNBIT_CHUNK_SEQ -- requirements
Module: sub_nnbit_chunk_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 8, operand/result width; SHALL be a multiple of CHUNK_WIDTH.
REQ-002 Parameter CHUNK_WIDTH, default 4, bits subtracted per cycle with lookahead borrow inside the chunk.
REQ-003 i_clk  in  1  sole clock, all state updates on rising edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_valid  in  1  request valid.
REQ-006 o_ready  out  1  block can accept a request.
REQ-007 i_num_a  in  DATA_WIDTH  minuend.
REQ-008 i_num_b  in  DATA_WIDTH  subtrahend.
REQ-009 i_brw  in  1  borrow-in.
REQ-010 o_valid  out  1  result valid.
REQ-011 i_ready  in  1  consumer accepts result.
REQ-012 o_res  out  DATA_WIDTH  difference.
REQ-013 o_brw  out  1  borrow-out.
REQ-014 o_ovf  out  1  signed overflow; present only with SUB_OVERFLOW_FLAG_EN.

Function
REQ-015 FSM states IDLE, CALC, DONE; IDLE after reset.
REQ-016 o_ready SHALL be 1 only in IDLE; accept = i_valid & o_ready.
REQ-017 On accept: latch a, b, i_brw; chunk index = 0; go to CALC.
REQ-018 Each CALC cycle: compute chunk k = a[k] - b[k] - borrow using lookahead borrow (g = ~a&b, p = ~(a^b)), write into o_res chunk k, register chunk borrow-out as next borrow; k increments.
REQ-019 After the edge processing chunk N-1 (N = DATA_WIDTH/CHUNK_WIDTH): go to DONE, o_valid = 1, o_brw = final borrow.
REQ-020 Latency: o_valid rises exactly N rising edges after the accept edge.
REQ-021 Result: o_res = (a - b - i_brw) mod 2^DATA_WIDTH; o_brw = 1 iff a < b + i_brw (unsigned).
REQ-022 DONE: o_res/o_brw/o_valid held stable while i_ready = 0 (unbounded backpressure).
REQ-023 DONE and i_ready = 1: transfer; next state IDLE, o_valid = 0; o_ready = 1 the following cycle (no same-cycle re-accept).
REQ-024 i_valid/operand changes outside IDLE SHALL be ignored.
REQ-025 N = 1 (CHUNK_WIDTH = DATA_WIDTH) SHALL be legal: single CALC cycle.

Reset
REQ-026 i_rst = 1 at a rising edge: state IDLE, o_ready = 1 next cycle, o_valid = 0, o_res = 0, o_brw = 0, o_ovf = 0, chunk index 0.
REQ-027 Reset during CALC or DONE SHALL abort the operation; no result is presented.
REQ-028 Reset has priority over accept and transfer in the same cycle.

Configuration
REQ-029 Macro SUB_OVERFLOW_FLAG_EN defined: o_ovf port exists, set in DONE to (a[MSB] != b[MSB]) & (o_res[MSB] != a[MSB]), held with o_res.
REQ-030 Macro undefined: no o_ovf port, no overflow logic; all other behaviour identical.

Verification (DATA_WIDTH 8, CHUNK_WIDTH 4)
REQ-031 a=0xF0, b=0xF0, brw=0 -> o_res=0x00, o_brw=0, o_valid 2 edges after accept.
REQ-032 a=0x00, b=0x01, brw=0 -> o_res=0xFF, o_brw=1; a=0x05, b=0x05, brw=1 -> o_res=0xFF, o_brw=1 (cross-chunk borrow).
REQ-033 With SUB_OVERFLOW_FLAG_EN: a=0x80, b=0x01, brw=0 -> o_res=0x7F, o_brw=0, o_ovf=1; a=0xFC, b=0xF9 -> o_res=0x03, o_ovf=0.
REQ-034 a=0xFE, b=0xF9, brw=1, i_ready held 0 for 5 cycles -> o_res=0x04, o_brw=0 stable, o_valid=1 throughout; i_valid toggled meanwhile has no effect.
REQ-035 Accept then assert i_rst in first CALC cycle -> o_valid never rises, o_res=0, o_ready=1 the cycle after reset deasserts; next request a=0x10, b=0x20 -> o_res=0xF0, o_brw=1.
REQ-036 Back-to-back: i_valid and i_ready held 1 -> accepts spaced N+2 cycles apart, every result matches a - b - brw.
